moving_sum: RTL

Parametrised streaming sum engine that sits between the chip's parallel input pins and its output register in ChipTop. It is the successor to the fixed 8-bit-in / 10-bit-out datapath. It accepts qualified unsigned samples and produces either a sliding-window sum over the last DEPTH samples or a block sum every DEPTH samples. The mode is selected at run time, output width grows with depth, and there is an explicit valid qualifier and a synchronous clear.

---
 rtl/moving_sum_pkg.sv | 22 ++
 rtl/sample_ring.sv | 40 ++++
 rtl/moving_sum.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/moving_sum_pkg.sv
// Shared types and helpers for the moving_sum streaming sum engine.
package moving_sum_pkg;

  // Run-time operating mode, driven straight from the mode pin.
  typedef enum logic {
    SLIDE = 1'b0,
    BLOCK = 1'b1
  } mode_e;

  // Control FSM states: FILL/RUN serve SLIDE mode, ACC serves BLOCK mode.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    ACC  = 2'd2
  } state_e;

  // Sum width large enough that depth full-scale samples never wrap.
  function automatic int unsigned sum_width(input int unsigned in_w, input int unsigned depth);
    return in_w + int'($clog2(depth));
  endfunction

endpackage

// File: rtl/sample_ring.sv
// DEPTH-entry sample ring buffer.
// Ports:
//   clk        sole clock
//   flush_i    synchronous flush: zeroes every entry and the write pointer
//   wr_en_i    write wr_data_i at the write pointer, then advance it
//   wr_data_i  sample to store
//   oldest_c   combinational read of the entry the next write will replace
module sample_ring #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            flush_i,
  input  logic            wr_en_i,
  input  logic [IN_W-1:0] wr_data_i,
  output logic [IN_W-1:0] oldest_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [IN_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;

  // DEPTH is a power of two, so the pointer wraps DEPTH-1 -> 0 by overflow.
  always_ff @(posedge clk) begin
    if (flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
      wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
    end
  end

  // Once the ring is full, the slot about to be overwritten holds the oldest sample.
  assign oldest_c = mem_q[wr_ptr_q];

endmodule

// File: rtl/moving_sum.sv
// Streaming sum engine: sliding-window sum (SLIDE) or block sum (BLOCK)
// over DEPTH unsigned samples, one-cycle latency, one sample per cycle.
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset, dominates everything
//   clear      synchronous datapath flush (same effect as reset)
//   mode       0 = SLIDE, 1 = BLOCK; a change between cycles acts as clear
//   in_valid   qualifies in_data (no backpressure)
//   in_data    unsigned sample
//   out_valid  one-cycle qualifier for out_data
//   out_data   unsigned sum, held while out_valid is low
module moving_sum
  import moving_sum_pkg::*;
#(
  parameter  int unsigned IN_W  = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned OUT_W = sum_width(IN_W, DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data
);

  localparam int unsigned CNT_W = $clog2(DEPTH);

  mode_e            mode_in;
  mode_e            mode_q;
  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic             clear_c;
  logic             last_c;
  logic             wr_en_c;
  logic [IN_W-1:0]  oldest_c;
  logic [OUT_W-1:0] sum_c;
  state_e           home_c;

  assign mode_in = mode_e'(mode);

  // A mode flip between consecutive cycles flushes the datapath like clear.
  assign clear_c = clear | (mode_in != mode_q);
  assign last_c  = (cnt_q == CNT_W'(DEPTH - 1));
  assign sum_c   = acc_q + OUT_W'(in_data);
  assign home_c  = (mode_in == BLOCK) ? ACC : FILL;

  sample_ring #(
    .IN_W  (IN_W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk       (clk),
    .flush_i   (reset | clear_c),
    .wr_en_i   (wr_en_c),
    .wr_data_i (in_data),
    .oldest_c  (oldest_c)
  );

  // State, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= home_c;
      mode_q      <= mode_in;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_in;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    wr_en_c     = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    if (clear_c) begin
      // Aborts any partial window/block; a sample in this cycle is dropped.
      state_d    = home_c;
      acc_d      = '0;
      cnt_d      = '0;
      out_data_d = '0;
    end else if (in_valid) begin
      unique case (state_q)
        FILL: begin
          wr_en_c = 1'b1;
          acc_d   = sum_c;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_c) begin
            out_valid_d = 1'b1;
            out_data_d  = sum_c;
            state_d     = RUN;
          end
        end
        RUN: begin
          // The oldest sample is part of acc, so this subtraction cannot underflow.
          wr_en_c     = 1'b1;
          acc_d       = sum_c - OUT_W'(oldest_c);
          out_valid_d = 1'b1;
          out_data_d  = acc_d;
        end
        ACC: begin
          if (last_c) begin
            out_valid_d = 1'b1;
            out_data_d  = sum_c;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            acc_d = sum_c;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = home_c;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
